// File: rtl/lc3b_mem_ctrl_if.sv
// lc3b_mem_ctrl_if: external 16-bit memory port between the controller (master) and memory (slave).
interface lc3b_mem_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_rdata, mem_ack);
    modport slave  (input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/lc3b_mem_ctrl.sv
// lc3b_mem_ctrl: LC-3b MAR/MDR memory stage with req/ack port, byte sizing and watchdog.
// Optional LC3B_UNALIGNED_TRAP_EN traps odd-address word accesses and adds err_unaligned.
module lc3b_mem_ctrl #(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic               clk_50,
    input  logic               reset_n,
    input  logic [15:0]        bus,
    input  logic               ldmar,
    input  logic               ldmdr,
    input  logic               mio_en,
    input  logic               rw,
    input  logic               datasize,
    output logic [15:0]        mar,
    output logic [15:0]        mdr,
    output logic               r,
    lc3b_mem_ctrl_if.master    mem,
    output logic               err_timeout
`ifdef LC3B_UNALIGNED_TRAP_EN
    , output logic             err_unaligned
`endif
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT_ACK, DONE, GUARD} state_t;
    state_t                state_q;
    logic [15:0]           mar_q, mdr_q, rdata_d;
    logic [1:0]            be_q, be_d;
    logic [TIMEOUT_W-1:0]  cnt_q;
    logic                  rw_q, size_q, r_q, req_q, we_q, err_to_q, unaligned_d;
    always_comb begin
        be_d    = datasize ? 2'b11 : (mar_q[0] ? 2'b10 : 2'b01);
        rdata_d = size_q ? mem.mem_rdata
                : mar_q[0] ? {{8{mem.mem_rdata[15]}}, mem.mem_rdata[15:8]}
                : {{8{mem.mem_rdata[7]}}, mem.mem_rdata[7:0]};
    end
`ifdef LC3B_UNALIGNED_TRAP_EN
    logic err_un_q;
    assign unaligned_d   = datasize & mar_q[0];
    assign err_unaligned = err_un_q;
`else
    assign unaligned_d = 1'b0;
`endif
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mar_q    <= '0;
            mdr_q    <= '0;
            be_q     <= '0;
            cnt_q    <= '0;
            rw_q     <= 1'b0;
            size_q   <= 1'b0;
            r_q      <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            err_to_q <= 1'b0;
`ifdef LC3B_UNALIGNED_TRAP_EN
            err_un_q <= 1'b0;
`endif
        end else begin
            r_q <= 1'b0;
`ifdef LC3B_UNALIGNED_TRAP_EN
            err_un_q <= 1'b0;
`endif
            if (ldmar && state_q == IDLE) mar_q <= bus;
            if (ldmdr && !mio_en) mdr_q <= datasize ? bus : {2{bus[7:0]}};
            case (state_q)
                IDLE: if (mio_en) begin
                    rw_q   <= rw;
                    size_q <= datasize;
                    if (unaligned_d) begin
                        state_q <= DONE;
                        r_q     <= 1'b1;
`ifdef LC3B_UNALIGNED_TRAP_EN
                        err_un_q <= 1'b1;
`endif
                    end else begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        we_q    <= rw;
                        be_q    <= be_d;
                        cnt_q   <= '0;
                    end
                end
                REQ: state_q <= WAIT_ACK;
                WAIT_ACK: if (mem.mem_ack) begin
                    state_q <= DONE;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    r_q     <= 1'b1;
                    if (!rw_q && ldmdr) mdr_q <= rdata_d;
                end else if (cnt_q == TIMEOUT_W'(TIMEOUT)) begin
                    // Abort: release the bus and still complete so control cannot hang.
                    state_q  <= DONE;
                    req_q    <= 1'b0;
                    we_q     <= 1'b0;
                    r_q      <= 1'b1;
                    err_to_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                DONE:    state_q <= GUARD;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign mar           = mar_q;
    assign mdr           = mdr_q;
    assign r             = r_q;
    assign err_timeout   = err_to_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = mar_q[15:1];
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = mdr_q;
endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
// tb_lc3b_mem_ctrl: randomized self-checking bench for lc3b_mem_ctrl against a transaction-level model.
module tb_lc3b_mem_ctrl;
    localparam int TIMEOUT = 255;
    logic        clk_50 = 1'b0, reset_n = 1'b0;
    logic [15:0] bus = '0, mar, mdr;
    logic        ldmar = 0, ldmdr = 0, mio_en = 0, rw = 0, datasize = 0, r, err_timeout;
`ifdef LC3B_UNALIGNED_TRAP_EN
    logic        err_unaligned;
`endif
    lc3b_mem_ctrl_if m();
    lc3b_mem_ctrl #(.TIMEOUT(TIMEOUT), .TIMEOUT_W(8)) dut (
        .clk_50(clk_50), .reset_n(reset_n), .bus(bus), .ldmar(ldmar), .ldmdr(ldmdr),
        .mio_en(mio_en), .rw(rw), .datasize(datasize), .mar(mar), .mdr(mdr), .r(r),
        .mem(m), .err_timeout(err_timeout)
`ifdef LC3B_UNALIGNED_TRAP_EN
        , .err_unaligned(err_unaligned)
`endif
    );
    always #5 clk_50 = ~clk_50;

    int          n_cmp = 0, n_err = 0;
    logic [15:0] m_mar = '0, m_mdr = '0;

    function automatic logic [15:0] load_val(input logic [15:0] rd, input logic [15:0] a, input logic sz);
        int b;
        if (sz) return rd;
        b = a[0] ? int'(rd) / 256 : int'(rd) % 256;
        return (b >= 128) ? 16'(b + 'hFF00) : 16'(b);
    endfunction

    task automatic load_mar(input logic [15:0] a);
        bus = a; ldmar = 1;
        @(negedge clk_50);
        ldmar = 0; m_mar = a;
        n_cmp++; if (mar !== a) begin n_err++; $display("FAIL load_mar got=%h exp=%h", mar, a); end
    endtask

    task automatic load_mdr(input logic [15:0] v, input logic sz);
        bus = v; datasize = sz; ldmdr = 1; mio_en = 0;
        @(negedge clk_50);
        ldmdr = 0;
        m_mdr = sz ? v : 16'((v % 256) * 257);
        n_cmp++; if (mdr !== m_mdr) begin n_err++; $display("FAIL load_mdr got=%h exp=%h", mdr, m_mdr); end
    endtask

    // One access; memory acks d cycles into WAIT_ACK, r expected 3+d cycles after mio_en is sampled.
    task automatic access(input logic w, input logic sz, input int d, input logic [15:0] rd, input logic ld, input logic drop);
        logic [15:0] exp_mdr;
        logic [1:0]  exp_be;
        exp_mdr = (!w && ld) ? load_val(rd, m_mar, sz) : m_mdr;
        exp_be  = sz ? 2'b11 : (m_mar[0] ? 2'b10 : 2'b01);
        mio_en = 1; rw = w; datasize = sz; ldmdr = ld; m.mem_ack = 0;
        for (int k = 1; k <= 4 + d; k++) begin
            @(negedge clk_50);
            if (drop && k == 1) mio_en = 0;
            if (k <= 2 + d) begin
                n_cmp++; if (m.mem_req !== 1'b1) begin n_err++; $display("FAIL req_held k=%0d got=%b exp=1", k, m.mem_req); end
                n_cmp++; if (m.mem_addr !== m_mar[15:1]) begin n_err++; $display("FAIL mem_addr got=%h exp=%h", m.mem_addr, m_mar[15:1]); end
                n_cmp++; if (m.mem_be !== exp_be) begin n_err++; $display("FAIL mem_be got=%b exp=%b", m.mem_be, exp_be); end
                n_cmp++; if (m.mem_we !== w) begin n_err++; $display("FAIL mem_we got=%b exp=%b", m.mem_we, w); end
                n_cmp++; if (m.mem_wdata !== m_mdr) begin n_err++; $display("FAIL mem_wdata got=%h exp=%h", m.mem_wdata, m_mdr); end
                n_cmp++; if (r !== 1'b0) begin n_err++; $display("FAIL r_early k=%0d got=%b exp=0", k, r); end
            end
            if (k == 2 + d) begin m.mem_ack = 1; m.mem_rdata = rd; end
            if (k == 3 + d) begin
                m.mem_ack = 0; m.mem_rdata = 16'($urandom);
                n_cmp++; if (r !== 1'b1) begin n_err++; $display("FAIL r_pulse got=%b exp=1", r); end
                n_cmp++; if (m.mem_req !== 1'b0) begin n_err++; $display("FAIL req_drop got=%b exp=0", m.mem_req); end
                n_cmp++; if (mdr !== exp_mdr) begin n_err++; $display("FAIL mdr_after got=%h exp=%h", mdr, exp_mdr); end
                mio_en = 0; ldmdr = 0;
            end
            if (k == 4 + d) begin
                n_cmp++; if (r !== 1'b0) begin n_err++; $display("FAIL r_single got=%b exp=0", r); end
            end
        end
        m_mdr = exp_mdr;
        @(negedge clk_50);
    endtask

    task automatic test_reset;
        n_cmp++; if ({mar, mdr, r, m.mem_req, m.mem_we, m.mem_be, err_timeout} !== '0) begin
            n_err++; $display("FAIL reset got mar=%h mdr=%h r=%b req=%b we=%b be=%b to=%b exp=all zero",
                mar, mdr, r, m.mem_req, m.mem_we, m.mem_be, err_timeout);
        end
    endtask

    task automatic test_word_read;
        load_mar(16'h3000);
        access(1'b0, 1'b1, 2, 16'hBEEF, 1'b1, 1'b0);
        n_cmp++; if (mdr !== 16'hBEEF) begin n_err++; $display("FAIL word_read mdr got=%h exp=BEEF", mdr); end
    endtask

    task automatic test_byte_read;
        load_mar(16'h3001);
        access(1'b0, 1'b0, 1, 16'h80FF, 1'b1, 1'b0);
        n_cmp++; if (mdr !== 16'hFF80) begin n_err++; $display("FAIL byte_read mdr got=%h exp=FF80", mdr); end
    endtask

    task automatic test_byte_write;
        load_mdr(16'h1234, 1'b0);
        n_cmp++; if (mdr !== 16'h3434) begin n_err++; $display("FAIL byte_repl mdr got=%h exp=3434", mdr); end
        load_mar(16'h4000);
        access(1'b1, 1'b0, 0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_mid_drop;
        load_mar(16'h0A42);
        access(1'b0, 1'b1, 1, 16'h5A5A, 1'b0, 1'b1);
    endtask

    task automatic test_stray_ack;
        m.mem_ack = 1; m.mem_rdata = 16'h1111;
        repeat (2) @(negedge clk_50);
        m.mem_ack = 0;
        n_cmp++; if ({r, m.mem_req} !== 2'b00 || mdr !== m_mdr) begin
            n_err++; $display("FAIL stray_ack got r=%b req=%b mdr=%h exp r=0 req=0 mdr=%h", r, m.mem_req, mdr, m_mdr);
        end
    endtask

    task automatic test_back_to_back;
        load_mar(16'h0100);
        mio_en = 1; rw = 0; datasize = 1; ldmdr = 0; m.mem_ack = 1; m.mem_rdata = 16'hDEAD;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk_50);
            n_cmp++; if (r !== (k % 5 == 3)) begin n_err++; $display("FAIL b2b_r k=%0d got=%b exp=%b", k, r, k % 5 == 3); end
            n_cmp++; if (m.mem_req !== (k % 5 == 1 || k % 5 == 2)) begin
                n_err++; $display("FAIL b2b_req k=%0d got=%b exp=%b", k, m.mem_req, k % 5 == 1 || k % 5 == 2);
            end
            if (k == 13) begin mio_en = 0; m.mem_ack = 0; end
        end
        @(negedge clk_50);
        n_cmp++; if (mdr !== m_mdr) begin n_err++; $display("FAIL b2b_mdr got=%h exp=%h", mdr, m_mdr); end
    endtask

    task automatic test_timeout;
        int got = 0;
        load_mar(16'h2000);
        mio_en = 1; rw = 0; datasize = 1; ldmdr = 1; m.mem_ack = 0;
        for (int k = 1; k <= 400 && got == 0; k++) begin
            @(negedge clk_50);
            if (k == TIMEOUT) begin
                n_cmp++; if ({m.mem_req, err_timeout} !== 2'b10) begin
                    n_err++; $display("FAIL timeout_early got req=%b to=%b exp req=1 to=0", m.mem_req, err_timeout);
                end
            end
            if (r) got = k;
        end
        mio_en = 0; ldmdr = 0;
        n_cmp++; if (got < TIMEOUT + 1 || got > TIMEOUT + 3) begin
            n_err++; $display("FAIL timeout_r cycle got=%0d exp=%0d..%0d", got, TIMEOUT + 1, TIMEOUT + 3);
        end
        n_cmp++; if ({m.mem_req, err_timeout} !== 2'b01 || mdr !== m_mdr) begin
            n_err++; $display("FAIL timeout_state got req=%b to=%b mdr=%h exp req=0 to=1 mdr=%h", m.mem_req, err_timeout, mdr, m_mdr);
        end
        repeat (2) @(negedge clk_50);
        load_mar(16'h2002);
        access(1'b0, 1'b1, 0, 16'h7777, 1'b1, 1'b0);
        n_cmp++; if (err_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_sticky got=%b exp=1", err_timeout); end
    endtask

    task automatic test_async_reset;
        load_mar(16'h5000);
        mio_en = 1; rw = 0; datasize = 1; ldmdr = 1; m.mem_ack = 0;
        repeat (2) @(negedge clk_50);
        reset_n = 0;
        #1;
        n_cmp++; if ({m.mem_req, mar, mdr, err_timeout} !== '0) begin
            n_err++; $display("FAIL async_reset got req=%b mar=%h mdr=%h to=%b exp all zero", m.mem_req, mar, mdr, err_timeout);
        end
        @(negedge clk_50);
        mio_en = 0; ldmdr = 0; reset_n = 1; m_mar = '0; m_mdr = '0;
        @(negedge clk_50);
        load_mar(16'h3000);
        access(1'b0, 1'b1, 0, 16'hC0DE, 1'b1, 1'b0);
    endtask

    task automatic test_random;
        logic [15:0] a;
        logic        w, sz;
        for (int i = 0; i < 16; i++) begin
            a = 16'($urandom); w = 1'($urandom); sz = 1'($urandom);
`ifdef LC3B_UNALIGNED_TRAP_EN
            if (sz) a[0] = 1'b0;
`endif
            if (w) load_mdr(16'($urandom), 1'($urandom));
            load_mar(a);
            access(w, sz, $urandom_range(0, 3), 16'($urandom), 1'($urandom), 1'b0);
        end
    endtask

`ifdef LC3B_UNALIGNED_TRAP_EN
    task automatic test_unaligned;
        load_mar(16'h3001);
        mio_en = 1; rw = 0; datasize = 1; ldmdr = 1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_50);
            n_cmp++; if (m.mem_req !== 1'b0) begin n_err++; $display("FAIL unal_req k=%0d got=%b exp=0", k, m.mem_req); end
            n_cmp++; if ({r, err_unaligned} !== {2{k == 1}}) begin
                n_err++; $display("FAIL unal_pulse k=%0d got r=%b eu=%b exp=%b", k, r, err_unaligned, k == 1);
            end
            if (k == 1) begin mio_en = 0; ldmdr = 0; end
        end
        n_cmp++; if (mdr !== m_mdr) begin n_err++; $display("FAIL unal_mdr got=%h exp=%h", mdr, m_mdr); end
    endtask
`endif

    initial begin
        m.mem_ack = 0; m.mem_rdata = '0;
        repeat (3) @(negedge clk_50);
        test_reset;
        reset_n = 1;
        @(negedge clk_50);
        test_word_read;
        test_byte_read;
        test_byte_write;
        test_mid_drop;
        test_stray_ack;
        test_back_to_back;
        test_random;
`ifdef LC3B_UNALIGNED_TRAP_EN
        test_unaligned;
`endif
        test_timeout;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
